gray_addr_block: RTL and testbench

- Stage directly downstream of the 2-bit Gray-code counter (two dff instances). Consumes counter outputs Q1/Q0 each cycle.
- On every count change, converts Gray to binary and reads a small register file (datablock) at that address.
- Pushes {address, data} into a 2-entry output FIFO with valid/ready handshake.
- Flags illegal Gray transitions and output overruns in a sticky STATUS register.

---
 rtl/gab_pkg.sv | 30 +++
 rtl/gab_fifo2.sv | 68 ++++++
 rtl/gray_addr_block.sv | 128 ++++++++++++
 tb/tb_gray_addr_block.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gab_pkg.sv
// Shared definitions for the Gray-address stage (gray_addr_block).
// Optional error counter is enabled by defining GAB_ERRCNT_EN.
package gab_pkg;

    localparam int CW_DEF = 2;   // counter / address width
    localparam int DW_DEF = 8;   // datablock word width
    localparam int GW_MAX = 4;   // widest Gray count supported

    // STATUS bit positions
    localparam int ST_SEQ = 0;   // illegal Gray step seen
    localparam int ST_OVR = 1;   // entry dropped on a full FIFO

    // One output FIFO entry at the default widths
    typedef struct packed {
        logic [CW_DEF-1:0] addr;
        logic [DW_DEF-1:0] data;
    } gab_entry_t;

    // Gray to binary; narrower counts are zero-extended by the caller,
    // which leaves the low bits of the result unchanged.
    function automatic logic [GW_MAX-1:0] gray2bin(input logic [GW_MAX-1:0] g);
        logic [GW_MAX-1:0] b;
        b[GW_MAX-1] = g[GW_MAX-1];
        for (int i = GW_MAX - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gab_fifo2.sv
// Two-entry FIFO for gray_addr_block with simultaneous push/pop support.
// A push while full is ignored unless the same edge also pops.
// The head register keeps its last value after the final pop.
module gab_fifo2 #(
    parameter int W = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] slot0_q, slot0_d;   // head
    logic [W-1:0] slot1_q, slot1_d;   // second entry
    logic [1:0]   count_q, count_d;
    logic         do_pop, do_push;

    // Next-state: pop only when occupied; push accepted unless full without a pop
    always_comb begin
        do_pop  = pop && (count_q != 2'd0);
        do_push = push && ((count_q != 2'd2) || do_pop);
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10: begin
                if (count_q == 2'd0) slot0_d = din;
                else                 slot1_d = din;
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                if (count_q == 2'd2) slot0_d = slot1_q;
                count_d = count_q - 2'd1;
            end
            2'b11: begin
                if (count_q == 2'd1) begin
                    slot0_d = din;
                end else begin
                    slot0_d = slot1_q;
                    slot1_d = din;
                end
            end
            default: ;
        endcase
    end

    // Storage and occupancy registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= 2'd0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign dout  = slot0_q;
    assign empty = (count_q == 2'd0);
    assign full  = (count_q == 2'd2);

endmodule

// File: rtl/gray_addr_block.sv
// gray_addr_block: samples an upstream Gray counter, reads the datablock at
// the decoded address on every count change and queues {addr, data} for a
// consumer. Sticky STATUS flags illegal Gray steps and dropped entries.
// Define GAB_ERRCNT_EN to build the saturating ERR_CNT counter.
//
// Output handshake: an entry is offered while DVALID=1 and leaves the FIFO
// on a rising CLK edge where DVALID && DREADY; DOUT/DOUT_ADDR are stable
// while DVALID=1 and DREADY=0, and hold the last entry when DVALID=0.
module gray_addr_block
    import gab_pkg::*;
#(
    parameter int CW = CW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [CW-1:0] Q_IN,
    input  logic          EN,
    input  logic          WE,
    input  logic [CW-1:0] WADDR,
    input  logic [DW-1:0] WDATA,
    output logic [CW-1:0] DOUT_ADDR,
    output logic [DW-1:0] DOUT,
    output logic          DVALID,
    input  logic          DREADY,
    input  logic          CLR_STATUS,
    output logic [1:0]    STATUS,
    output logic [7:0]    ERR_CNT
);

    localparam int EW     = CW + DW;
    localparam int NWORDS = 1 << CW;

    logic [CW-1:0] q_prev_q, q_prev_d;
    logic [1:0]    status_q, status_d;
    logic [DW-1:0] mem_q [NWORDS];
    logic [DW-1:0] mem_d [NWORDS];
    logic [CW-1:0] bin;
    logic [DW-1:0] rdata;
    logic [2:0]    flips;
    logic          chg, seq_err, ovr, pop;
    logic          fifo_full, fifo_empty;
    logic [EW-1:0] head;

    // Change detect, Gray step check and write-first datablock read
    always_comb begin
        bin   = CW'(gray2bin(GW_MAX'(Q_IN)));
        flips = 3'd0;
        for (int i = 0; i < CW; i++) begin
            flips = flips + {2'b00, Q_IN[i] ^ q_prev_q[i]};
        end
        chg      = EN && (Q_IN != q_prev_q);
        seq_err  = chg && (flips != 3'd1);
        rdata    = (WE && (WADDR == bin)) ? WDATA : mem_q[bin];
        pop      = !fifo_empty && DREADY;
        ovr      = chg && fifo_full && !pop;
        q_prev_d = EN ? Q_IN : q_prev_q;
    end

    // Sticky flags: a new error in the clearing cycle wins over the clear
    always_comb begin
        status_d = CLR_STATUS ? 2'b00 : status_q;
        if (seq_err) status_d[ST_SEQ] = 1'b1;
        if (ovr)     status_d[ST_OVR] = 1'b1;
    end

    // Datablock write, independent of sampling
    always_comb begin
        mem_d = mem_q;
        if (WE) mem_d[WADDR] = WDATA;
    end

    // Datablock storage has no reset
    always_ff @(posedge CLK) begin
        mem_q <= mem_d;
    end

    // Previous count and status registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_prev_q <= '0;
            status_q <= 2'b00;
        end else begin
            q_prev_q <= q_prev_d;
            status_q <= status_d;
        end
    end

`ifdef GAB_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    // Saturating error count; one per error kind in the cycle
    always_comb begin
        err_sum   = (CLR_STATUS ? 9'd0 : {1'b0, err_cnt_q})
                  + {8'd0, seq_err} + {8'd0, ovr};
        err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
    end

    // Error counter register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_cnt_q <= 8'd0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign ERR_CNT = err_cnt_q;
`else
    assign ERR_CNT = 8'd0;
`endif

    gab_fifo2 #(
        .W(EW)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST_N),
        .push  (chg),
        .pop   (pop),
        .din   ({bin, rdata}),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign DVALID              = !fifo_empty;
    assign {DOUT_ADDR, DOUT}   = head;
    assign STATUS              = status_q;

endmodule

// File: tb/tb_gray_addr_block.sv
// Bench for gray_addr_block: directed vectors, a queue-based model of the
// block and a per-cycle compare against it, plus literal spot checks.
module tb_gray_addr_block;

    localparam int CW = 2;
    localparam int DW = 8;
    localparam int EW = 1 + CW + DW;   // {known, addr, data}

    logic          CLK = 1'b0;
    logic          RST_N;
    logic [CW-1:0] Q_IN;
    logic          EN;
    logic          WE;
    logic [CW-1:0] WADDR;
    logic [DW-1:0] WDATA;
    logic [CW-1:0] DOUT_ADDR;
    logic [DW-1:0] DOUT;
    logic          DVALID;
    logic          DREADY;
    logic          CLR_STATUS;
    logic [1:0]    STATUS;
    logic [7:0]    ERR_CNT;

    int n_vec = 0;
    int n_err = 0;
    bit cmp_en = 1'b0;

    gray_addr_block #(.CW(CW), .DW(DW)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Q_IN       (Q_IN),
        .EN         (EN),
        .WE         (WE),
        .WADDR      (WADDR),
        .WDATA      (WDATA),
        .DOUT_ADDR  (DOUT_ADDR),
        .DOUT       (DOUT),
        .DVALID     (DVALID),
        .DREADY     (DREADY),
        .CLR_STATUS (CLR_STATUS),
        .STATUS     (STATUS),
        .ERR_CNT    (ERR_CNT)
    );

    // ---------------- clock ----------------
    always #5 CLK = ~CLK;

    // ---------------- model ----------------
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] m_hold = '0;
    logic [DW-1:0] m_mem[4];
    bit            m_known[4];
    logic [CW-1:0] m_prev = '0;
    logic [1:0]    m_status = 2'b00;
    int            m_errcnt = 0;
    logic [CW-1:0] m_bin;
    logic [DW-1:0] m_rdata;
    bit            m_rknown, m_chg, m_seq, m_ovr;

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            exp_q.delete();
            m_hold   = '0;
            m_hold[EW-1] = 1'b1;
            m_prev   = '0;
            m_status = 2'b00;
            m_errcnt = 0;
            for (int i = 0; i < 4; i++) m_known[i] = 1'b0;
        end else begin
            m_bin = Q_IN ^ (Q_IN >> 1);
            m_chg = EN && (Q_IN != m_prev);
            m_seq = m_chg && ($countones(Q_IN ^ m_prev) > 1);
            if (WE && WADDR == m_bin) begin
                m_rdata = WDATA; m_rknown = 1'b1;
            end else begin
                m_rdata = m_mem[m_bin]; m_rknown = m_known[m_bin];
            end
            if (exp_q.size() != 0 && DREADY) m_hold = exp_q.pop_front();
            m_ovr = 1'b0;
            if (m_chg) begin
                if (exp_q.size() < 2) exp_q.push_back({m_rknown, m_bin, m_rdata});
                else m_ovr = 1'b1;
            end
            if (CLR_STATUS) m_status = 2'b00;
            if (m_seq) m_status[0] = 1'b1;
            if (m_ovr) m_status[1] = 1'b1;
`ifdef GAB_ERRCNT_EN
            if (CLR_STATUS) m_errcnt = 0;
            m_errcnt = m_errcnt + int'(m_seq) + int'(m_ovr);
            if (m_errcnt > 255) m_errcnt = 255;
`endif
            if (WE) begin
                m_mem[WADDR] = WDATA; m_known[WADDR] = 1'b1;
            end
            if (EN) m_prev = Q_IN;
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [EW-1:0] cur;
    always @(negedge CLK) begin
        if (cmp_en) begin
            cur = (exp_q.size() != 0) ? exp_q[0] : m_hold;
            chk("dvalid", 32'(DVALID), 32'(exp_q.size() != 0));
            chk("dout_addr", 32'(DOUT_ADDR), 32'(cur[DW +: CW]));
            if (cur[EW-1]) chk("dout", 32'(DOUT), 32'(cur[DW-1:0]));
            chk("status", 32'(STATUS), 32'(m_status));
            chk("err_cnt", 32'(ERR_CNT), 32'(m_errcnt));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    task automatic lit_head(input string name, input logic [CW-1:0] a, input logic [DW-1:0] d);
        chk({name, "_v"}, 32'(DVALID), 32'd1);
        chk({name, "_a"}, 32'(DOUT_ADDR), 32'(a));
        chk({name, "_d"}, 32'(DOUT), 32'(d));
    endtask

    localparam logic [7:0] ECNT_SAT = `ifdef GAB_ERRCNT_EN 8'd255 `else 8'd0 `endif;
    localparam logic [7:0] ECNT_ONE = `ifdef GAB_ERRCNT_EN 8'd1 `else 8'd0 `endif;
    localparam logic [7:0] ECNT_TWO = `ifdef GAB_ERRCNT_EN 8'd2 `else 8'd0 `endif;

    // ---------------- stimulus ----------------
    initial begin
        RST_N = 1'b0; EN = 1'b0; Q_IN = '0; WE = 1'b0; WADDR = '0; WDATA = '0;
        DREADY = 1'b0; CLR_STATUS = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_dvalid", 32'(DVALID), 32'd0);
        chk("rst_addr", 32'(DOUT_ADDR), 32'd0);
        chk("rst_dout", 32'(DOUT), 32'd0);
        chk("rst_status", 32'(STATUS), 32'd0);
        chk("rst_errcnt", 32'(ERR_CNT), 32'd0);
        RST_N = 1'b1;
        cmp_en = 1'b1;

        // Load datablock with sampling off
        for (int i = 0; i < 4; i++) begin
            WE = 1'b1; WADDR = CW'(i); WDATA = 8'hA0 + 8'(i); step();
        end
        WE = 1'b0;

        // Legal Gray walk, consumer always ready
        EN = 1'b1; DREADY = 1'b1; Q_IN = 2'b00; step();
        chk("idle_dvalid", 32'(DVALID), 32'd0);
        Q_IN = 2'b01; step(); lit_head("walk1", 2'd1, 8'hA1);
        Q_IN = 2'b11; step(); lit_head("walk2", 2'd2, 8'hA2);
        Q_IN = 2'b10; step(); lit_head("walk3", 2'd3, 8'hA3);
        Q_IN = 2'b00; step(); lit_head("walk0", 2'd0, 8'hA0);
        step();
        chk("hold_dvalid", 32'(DVALID), 32'd0);
        chk("hold_dout", 32'(DOUT), 32'hA0);
        chk("walk_status", 32'(STATUS), 32'd0);

        // Two-bit step flags an error but still pushes
        Q_IN = 2'b11; step();
        chk("seq_status", 32'(STATUS), 32'd1);
        lit_head("seq_entry", 2'd2, 8'hA2);
        step();
        CLR_STATUS = 1'b1; step(); CLR_STATUS = 1'b0;
        chk("clr_status", 32'(STATUS), 32'd0);

        // Overrun: consumer stalled across three changes
        DREADY = 1'b0;
        Q_IN = 2'b01; step();
        Q_IN = 2'b11; step();
        Q_IN = 2'b10; step();
        chk("ovr_status", 32'(STATUS), 32'd2);
        lit_head("ovr_head1", 2'd1, 8'hA1);
        DREADY = 1'b1; step();
        lit_head("ovr_head2", 2'd2, 8'hA2);
        step();
        chk("ovr_drain", 32'(DVALID), 32'd0);
        CLR_STATUS = 1'b1; step(); CLR_STATUS = 1'b0;

        // Write-first bypass on the address being read
        Q_IN = 2'b00; step();
        Q_IN = 2'b01; step();
        Q_IN = 2'b11; WE = 1'b1; WADDR = 2'd2; WDATA = 8'h5C; step();
        WE = 1'b0;
        lit_head("bypass", 2'd2, 8'h5C);
        step();

        // Full FIFO with simultaneous push and pop: no overrun
        DREADY = 1'b0;
        Q_IN = 2'b10; step();
        Q_IN = 2'b00; step();
        DREADY = 1'b1; Q_IN = 2'b01; step();
        lit_head("pp_head0", 2'd0, 8'hA0);
        chk("pp_status", 32'(STATUS), 32'd0);
        step();
        lit_head("pp_head1", 2'd1, 8'hA1);
        step();

        // Clear and error in the same cycle: error wins
        Q_IN = 2'b10; CLR_STATUS = 1'b1; step(); CLR_STATUS = 1'b0;
        chk("win_status", 32'(STATUS), 32'd1);
        chk("win_errcnt", 32'(ERR_CNT), 32'(ECNT_ONE));

        // Asynchronous reset with two entries queued
        DREADY = 1'b0; Q_IN = 2'b00; step();
        #2 RST_N = 1'b0;
        #1;
        chk("arst_dvalid", 32'(DVALID), 32'd0);
        chk("arst_status", 32'(STATUS), 32'd0);
        chk("arst_dout", 32'(DOUT), 32'd0);
        @(negedge CLK);
        Q_IN = 2'b00; RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("post_rst_nopush", 32'(DVALID), 32'd0);
        end

        // Many illegal steps drive the counter to saturation
        DREADY = 1'b1;
        for (int i = 0; i < 300; i++) begin
            Q_IN = (i % 2 == 0) ? 2'b11 : 2'b00;
            step();
        end
        chk("sat_errcnt", 32'(ERR_CNT), 32'(ECNT_SAT));
        chk("sat_status", 32'(STATUS), 32'd1);
        CLR_STATUS = 1'b1; step(); CLR_STATUS = 1'b0;
        chk("clr_errcnt", 32'(ERR_CNT), 32'd0);

        // Sequence error and overrun together in one cycle
        DREADY = 1'b0;
        Q_IN = 2'b01; step();
        Q_IN = 2'b11; step();
        Q_IN = 2'b00; step();
        chk("both_status", 32'(STATUS), 32'd3);
        chk("both_errcnt", 32'(ERR_CNT), 32'(ECNT_TWO));

        // ---------------- report ----------------
        cmp_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
